// File: rtl/camera_config_sequencer.sv
// Walks an external register/value ROM table and issues one SCCB write per entry.
// The table can also hold timed-delay entries and an end marker.
module camera_config_sequencer #(
    parameter int CLK_FREQ = 25000000,
    parameter int DELAY_MS = 10,
    parameter int ROM_AW   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              sccb_ready,
    output logic              sccb_start,
    output logic [7:0]        sccb_addr,
    output logic [7:0]        sccb_data,
    output logic              busy,
    output logic              done
);

    localparam int DELAY_CYC_RAW = (CLK_FREQ / 1000) * DELAY_MS;
    // A zero-length delay entry still costs one cycle in DELAY.
    localparam int DELAY_CYC     = (DELAY_CYC_RAW < 1) ? 1 : DELAY_CYC_RAW;
    localparam int CW            = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;

    localparam logic [15:0] ENTRY_END   = 16'hFFFF;
    localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_DELAY,
        S_NEXT,
        S_DONE
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   delay_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            rom_addr      <= '0;
            sccb_start    <= 1'b0;
            sccb_addr     <= 8'h00;
            sccb_data     <= 8'h00;
            busy          <= 1'b0;
            done          <= 1'b0;
            delay_cnt_reg <= '0;
        end else begin
            sccb_start <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (cfg_start) begin
                        rom_addr  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state_reg <= S_FETCH;
                    end
                end
                // rom_addr has been presented for one cycle; rom_data is valid next.
                S_FETCH: state_reg <= S_DECODE;
                S_DECODE: begin
                    if (rom_data == ENTRY_END) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end else if (rom_data == ENTRY_DELAY) begin
                        delay_cnt_reg <= CW'(DELAY_CYC - 1);
                        state_reg     <= S_DELAY;
                    end else begin
                        sccb_addr <= rom_data[15:8];
                        sccb_data <= rom_data[7:0];
                        state_reg <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (sccb_ready) begin
                        sccb_start <= 1'b1;
                        state_reg  <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (!sccb_ready) state_reg <= S_WAIT_IDLE;
                end
                S_WAIT_IDLE: begin
                    if (sccb_ready) state_reg <= S_NEXT;
                end
                S_DELAY: begin
                    if (delay_cnt_reg == '0) state_reg <= S_NEXT;
                    else delay_cnt_reg <= delay_cnt_reg - 1'b1;
                end
                S_NEXT: begin
                    // Running off the end of the table without an END marker finishes the pass.
                    if (rom_addr == {ROM_AW{1'b1}}) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        rom_addr  <= rom_addr + 1'b1;
                        state_reg <= S_FETCH;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_config_sequencer.sv
// Scoreboard bench for camera_config_sequencer with a ROM model and a simple SCCB master model.
module tb_camera_config_sequencer;

    localparam int ROM_AW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start = 1'b0;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data = 16'h0000;
    logic              sccb_ready = 1'b1;
    logic              sccb_start;
    logic [7:0]        sccb_addr;
    logic [7:0]        sccb_data;
    logic              busy;
    logic              done;

    logic [15:0] rom [16];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          extra_hold = 0;
    int          hold_cnt = 0;
    logic [15:0] exp_q [$];
    int          start_cyc [$];
    logic        prev_start = 1'b0;

    camera_config_sequencer #(
        .CLK_FREQ(1000),
        .DELAY_MS(3),
        .ROM_AW  (ROM_AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .sccb_ready(sccb_ready),
        .sccb_start(sccb_start),
        .sccb_addr (sccb_addr),
        .sccb_data (sccb_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    // SCCB master model: ready drops the cycle after start, back after 20 (+extra) cycles.
    always @(posedge clk) begin
        if (sccb_start) begin
            sccb_ready <= 1'b0;
            hold_cnt   <= 20 + extra_hold;
        end else if (hold_cnt > 1) begin
            hold_cnt <= hold_cnt - 1;
        end else if (hold_cnt == 1) begin
            hold_cnt   <= 0;
            sccb_ready <= 1'b1;
        end
    end

    // Monitor: pops the expected write for every start pulse and checks the handshake rules.
    always @(negedge clk) begin
        logic [15:0] e;
        if (sccb_start) begin
            start_cyc.push_back(cyc);
            $display("txn cyc=%0d addr=%02h data=%02h", cyc, sccb_addr, sccb_data);
            total++;
            if (!sccb_ready) begin
                bad++;
                $display("FAIL start_while_not_ready actual=0 required=1");
            end
            total++;
            if (prev_start) begin
                bad++;
                $display("FAIL start_two_cycles actual=1 required=0");
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write actual=%02h%02h required=none", sccb_addr, sccb_data);
            end else begin
                e = exp_q.pop_front();
                if ({sccb_addr, sccb_data} !== e) begin
                    bad++;
                    $display("FAIL write_value actual=%02h%02h required=%04h", sccb_addr, sccb_data, e);
                end
            end
        end
        prev_start = sccb_start;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) cfg_start = 1'b1;
        @(negedge clk) cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_starts(input int cnt, input int budget);
        int n = 0;
        while (start_cyc.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("start_within_budget", {31'd0, start_cyc.size() >= cnt}, 32'd1);
    endtask

    task automatic load_basic_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1104;
        rom[3] = 16'hFFFF;
    endtask

    function automatic int gap01();
        if (start_cyc.size() < 2) return -1;
        return start_cyc[1] - start_cyc[0];
    endfunction

    initial begin
        int n;
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        check("reset_outputs", {22'd0, sccb_start, busy, done, sccb_addr[6:0]}, 32'd0);
        check("reset_data", 32'({sccb_addr, sccb_data}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: write, delay, write, end
        load_basic_rom();
        start_cyc.delete();
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1104);
        pulse_start();
        wait_done(500);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_writes", 32'(start_cyc.size()), 32'd2);
        check("t1_gap", 32'(gap01()), 32'd32);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // 2: master holds ready low 50 extra cycles on the first write
        start_cyc.delete();
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1104);
        extra_hold = 50;
        pulse_start();
        wait_starts(1, 100);
        @(negedge clk);
        extra_hold = 0;
        repeat (40) @(negedge clk);
        check("t2_ready_low", {31'd0, sccb_ready}, 32'd0);
        check("t2_addr_stable", 32'(sccb_addr), 32'h12);
        check("t2_one_write", 32'(start_cyc.size()), 32'd1);
        wait_done(500);
        check("t2_gap", 32'(gap01()), 32'd82);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3 + 4a: 16 writes without END, with an ignored cfg_start mid-pass
        for (int i = 0; i < 16; i++) rom[i] = 16'h0A55;
        start_cyc.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(16'h0A55);
        pulse_start();
        wait_starts(8, 600);
        pulse_start();
        check("t4_busy_mid", {31'd0, busy}, 32'd1);
        wait_done(1000);
        check("t3_rom_addr_end", 32'(rom_addr), 32'd15);
        repeat (5) @(negedge clk);
        check("t3_rom_addr_hold", 32'(rom_addr), 32'd15);
        check("t3_done_hold", {31'd0, done}, 32'd1);
        check("t3_writes", 32'(start_cyc.size()), 32'd16);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4b: replay after done
        start_cyc.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(16'h0A55);
        pulse_start();
        check("t4_done_cleared", {31'd0, done}, 32'd0);
        check("t4_busy_set", {31'd0, busy}, 32'd1);
        check("t4_rom_addr_zero", 32'(rom_addr), 32'd0);
        wait_done(1000);
        check("t4_writes", 32'(start_cyc.size()), 32'd16);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: reset while waiting for the master to go idle
        load_basic_rom();
        start_cyc.delete();
        exp_q.push_back(16'h1280);
        pulse_start();
        wait_starts(1, 100);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("t5_rst_flags", {29'd0, sccb_start, busy, done}, 32'd0);
        check("t5_rst_data", 32'({sccb_addr, sccb_data}), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_cyc.delete();
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1104);
        pulse_start();
        wait_done(500);
        check("t5_writes", 32'(start_cyc.size()), 32'd2);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: END as the first entry
        rom[0] = 16'hFFFF;
        start_cyc.delete();
        @(negedge clk) cfg_start = 1'b1;
        @(negedge clk) cfg_start = 1'b0;
        n = 1;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_latency_le4", {31'd0, n <= 4}, 32'd1);
        check("t6_no_writes", 32'(start_cyc.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
